ext_pipe: RTL and testbench

- Registered, parametrised immediate-extension stage for the pipelined CPU datapath. It sits between instruction decode and the ALU operand mux.
- Widens an IMM_W-bit immediate to DATA_W bits in one of several modes, including branch-offset and upper-placement modes.
- Uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure from a stalled downstream stage never drops or duplicates an immediate.
- Provides a pipeline flush and a saturating count of illegal-mode requests.

---
 rtl/ext_pipe.sv | 118 +++++++++++
 tb/tb_ext_pipe.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ext_pipe.sv
// Registered immediate-extension stage with a valid/ready handshake and a 2-entry skid buffer.
// Also keeps a saturating count of accepted illegal-mode requests.
module ext_pipe #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_mode,
  input  logic [IMM_W-1:0]  in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  illegal_cnt
);

  localparam int PAD = DATA_W - IMM_W;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] main_data, skid_data, ext_data, zext, sext;
  logic              main_ill, skid_ill, ext_ill;
  logic              accept, drain, load_main, load_skid, move_skid, cnt_inc;

  assign zext = {{PAD{1'b0}}, in_imm};
  assign sext = {{PAD{in_imm[IMM_W-1]}}, in_imm};

  always_comb begin
    ext_data = '0;
    ext_ill  = 1'b0;
    case (in_mode)
      3'b000:  ext_data = zext;
      3'b001:  ext_data = sext;
      3'b010:  ext_data = {in_imm, {PAD{1'b0}}};
      3'b011:  ext_data = sext << 2;
      3'b100:  ext_data = zext << 2;
      default: ext_ill  = 1'b1;
    endcase
  end

  // in_ready depends only on registered state (and reset), never on out_ready
  assign in_ready    = (state != TWO) && !reset;
  assign out_valid   = (state != EMPTY);
  assign out_data    = main_data;
  assign out_illegal = main_ill;
  assign accept      = in_valid && in_ready;
  assign drain       = out_valid && out_ready;

  always_comb begin
    state_next = state;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    move_skid  = 1'b0;
    cnt_inc    = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      cnt_inc = accept && ext_ill && (illegal_cnt != '1);
      case (state)
        EMPTY: begin
          if (accept) begin
            load_main  = 1'b1;
            state_next = ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            load_main = 1'b1;
          end else if (accept) begin
            load_skid  = 1'b1;
            state_next = TWO;
          end else if (drain) begin
            state_next = EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            move_skid  = 1'b1;
            state_next = ONE;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= EMPTY;
      main_data   <= '0;
      main_ill    <= 1'b0;
      skid_data   <= '0;
      skid_ill    <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      state <= state_next;
      if (load_main) begin
        main_data <= ext_data;
        main_ill  <= ext_ill;
      end else if (move_skid) begin
        main_data <= skid_data;
        main_ill  <= skid_ill;
      end
      if (load_skid) begin
        skid_data <= ext_data;
        skid_ill  <= ext_ill;
      end
      if (cnt_inc) illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
// Directed self-checking bench for ext_pipe (IMM_W=16, DATA_W=32, CNT_W=2).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_ext_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [2:0]  in_mode;
  logic [15:0] in_imm;
  logic [31:0] out_data;
  logic [1:0]  illegal_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] sweep_exp [6] = '{32'h00008001, 32'hFFFF8001, 32'h80010000,
                                 32'hFFFE0004, 32'h00020004, 32'h00000000};
  logic [1:0]  sat_exp [5]   = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

  ext_pipe #(.IMM_W(16), .DATA_W(32), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] m, input logic [15:0] imm,
                               input logic rdy);
    in_valid  = v;
    in_mode   = m;
    in_imm    = imm;
    out_ready = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0);
    waitCycle();
    checkOutput("in_ready_during_reset", 64'(in_ready), 64'd0);
    checkOutput("out_valid_during_reset", 64'(out_valid), 64'd0);
    reset = 1'b0;
    waitCycle();
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_data", 64'(out_data), 64'd0);
    checkOutput("reset_out_illegal", 64'(out_illegal), 64'd0);
    checkOutput("reset_cnt", 64'(illegal_cnt), 64'd0);

    $display("[TB] mode sweep");
    for (int m = 0; m < 6; m++) begin
      applyStimulus(1'b1, 3'(m), 16'h8001, 1'b1);
      waitCycle();
      checkOutput("sweep_valid", 64'(out_valid), 64'd1);
      checkOutput("sweep_data", 64'(out_data), 64'(sweep_exp[m]));
      checkOutput("sweep_illegal", 64'(out_illegal), (m == 5) ? 64'd1 : 64'd0);
    end
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1);
    waitCycle();
    checkOutput("sweep_drained", 64'(out_valid), 64'd0);
    checkOutput("sweep_cnt", 64'(illegal_cnt), 64'd1);

    $display("[TB] back-pressure");
    applyStimulus(1'b1, 3'd0, 16'd1, 1'b0);
    waitCycle();
    checkOutput("bp_first", 64'(out_data), 64'd1);
    checkOutput("bp_ready_one", 64'(in_ready), 64'd1);
    applyStimulus(1'b1, 3'd0, 16'd2, 1'b0);
    waitCycle();
    checkOutput("bp_full_ready", 64'(in_ready), 64'd0);
    checkOutput("bp_full_data", 64'(out_data), 64'd1);
    applyStimulus(1'b1, 3'd0, 16'd3, 1'b0);
    waitCycle();
    checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
    checkOutput("bp_hold_data", 64'(out_data), 64'd1);
    checkOutput("bp_hold_ready", 64'(in_ready), 64'd0);
    applyStimulus(1'b1, 3'd0, 16'd3, 1'b1);
    waitCycle();
    checkOutput("bp_out2", 64'(out_data), 64'd2);
    checkOutput("bp_ready_back", 64'(in_ready), 64'd1);
    waitCycle();
    checkOutput("bp_out3", 64'(out_data), 64'd3);
    applyStimulus(1'b1, 3'd0, 16'd4, 1'b1);
    waitCycle();
    checkOutput("bp_out4", 64'(out_data), 64'd4);
    applyStimulus(1'b0, 3'd0, 16'd0, 1'b1);
    waitCycle();
    checkOutput("bp_empty", 64'(out_valid), 64'd0);

    $display("[TB] full throughput");
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 3'd0, 16'(i + 100), 1'b1);
      checkOutput("tp_in_ready", 64'(in_ready), 64'd1);
      waitCycle();
      checkOutput("tp_valid", 64'(out_valid), 64'd1);
      checkOutput("tp_data", 64'(out_data), 64'(i + 100));
    end
    applyStimulus(1'b0, 3'd0, 16'd0, 1'b1);
    waitCycle();
    checkOutput("tp_drained", 64'(out_valid), 64'd0);

    $display("[TB] flush");
    applyStimulus(1'b1, 3'd0, 16'h11, 1'b0);
    waitCycle();
    applyStimulus(1'b1, 3'd0, 16'h22, 1'b0);
    waitCycle();
    checkOutput("fl_full", 64'(in_ready), 64'd0);
    flush = 1'b1;
    applyStimulus(1'b1, 3'd0, 16'h33, 1'b0);
    waitCycle();
    flush = 1'b0;
    checkOutput("fl_out_valid", 64'(out_valid), 64'd0);
    checkOutput("fl_in_ready", 64'(in_ready), 64'd1);
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1);
    waitCycle();
    checkOutput("fl_no_ghost", 64'(out_valid), 64'd0);
    flush = 1'b1;
    applyStimulus(1'b1, 3'd7, 16'h44, 1'b1);
    waitCycle();
    flush = 1'b0;
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1);
    checkOutput("fl_drop_valid", 64'(out_valid), 64'd0);
    checkOutput("fl_drop_cnt", 64'(illegal_cnt), 64'd1);

    $display("[TB] illegal counter saturation");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 3'd7, 16'(k), 1'b1);
      waitCycle();
      checkOutput("sat_cnt", 64'(illegal_cnt), 64'(sat_exp[k]));
      checkOutput("sat_illegal", 64'(out_illegal), 64'd1);
      checkOutput("sat_data", 64'(out_data), 64'd0);
    end
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1);
    flush = 1'b1;
    waitCycle();
    flush = 1'b0;
    checkOutput("sat_after_flush", 64'(illegal_cnt), 64'd3);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 3'd1, 16'h8001, 1'b0);
    waitCycle();
    applyStimulus(1'b1, 3'd1, 16'h7FFF, 1'b0);
    waitCycle();
    checkOutput("rs_skid_full", 64'(in_ready), 64'd0);
    checkOutput("rs_held_data", 64'(out_data), 64'hFFFF8001);
    reset = 1'b1;
    applyStimulus(1'b1, 3'd2, 16'h5555, 1'b0);
    waitCycle();
    checkOutput("rs_valid", 64'(out_valid), 64'd0);
    checkOutput("rs_data", 64'(out_data), 64'd0);
    checkOutput("rs_illegal", 64'(out_illegal), 64'd0);
    checkOutput("rs_cnt", 64'(illegal_cnt), 64'd0);
    checkOutput("rs_in_ready_held", 64'(in_ready), 64'd0);
    waitCycle();
    checkOutput("rs_in_ready_held2", 64'(in_ready), 64'd0);
    reset = 1'b0;
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1);
    #1;
    checkOutput("rs_in_ready_release", 64'(in_ready), 64'd1);
    checkOutput("rs_valid_release", 64'(out_valid), 64'd0);
    applyStimulus(1'b1, 3'd2, 16'h1234, 1'b1);
    waitCycle();
    checkOutput("rs_fresh_valid", 64'(out_valid), 64'd1);
    checkOutput("rs_fresh_data", 64'(out_data), 64'h12340000);
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1);
    waitCycle();
    checkOutput("rs_fresh_drained", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
